// File: rtl/commit_trace_buffer_if.sv
// Trace output stream of the commit trace buffer: first-word-fall-through
// head record with a valid/ready handshake toward a monitor or logger.
interface commit_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              trace_valid;
    logic              trace_ready;
    logic [1:0]        trace_type;
    logic [ADDR_W-1:0] trace_addr;
    logic [DATA_W-1:0] trace_data;

    // Producer side (the trace buffer)
    modport master (
        output trace_valid,
        output trace_type,
        output trace_addr,
        output trace_data,
        input  trace_ready
    );

    // Consumer side (monitor, logger, debug UART)
    modport slave (
        input  trace_valid,
        input  trace_type,
        input  trace_addr,
        input  trace_data,
        output trace_ready
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records register-file writes and data-memory
// accesses of the core into an in-order FIFO (up to two records per cycle,
// REG before MEM) and streams them out. The core is never stalled; records
// that do not fit are dropped and counted.
module commit_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 16,
    parameter int FILTER_X0 = 1,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = PTR_W + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_reg_write_sig,
    input  logic [4:0]            i_reg_num,
    input  logic [DATA_W-1:0]     i_reg_data,
    input  logic                  i_wr,
    input  logic                  i_rd,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W-1:0]     i_rd_data,
    commit_trace_buffer_if.master trace_m,
    output logic [CNT_W-1:0]      o_fifo_count,
    output logic [15:0]           o_drop_count,
    output logic                  o_overflow
);

    localparam logic [1:0] TYPE_REG    = 2'b01;
    localparam logic [1:0] TYPE_MEM_WR = 2'b10;
    localparam logic [1:0] TYPE_MEM_RD = 2'b11;

    // Record storage and bookkeeping
    logic [1:0]        r_type [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_drop;
    logic              r_overflow;

    // Event decode and push/drop arbitration
    logic              w_reg_ev;
    logic              w_mem_ev;
    logic [1:0]        w_n_ev;
    logic [CNT_W-1:0]  w_free;
    logic [1:0]        w_push_cnt;
    logic [1:0]        w_drop_cnt;
    logic              w_pop;
    logic [ADDR_W-1:0] w_reg_addr;
    logic [1:0]        w_mem_type;
    logic [DATA_W-1:0] w_mem_data;
    logic [1:0]        w_s0_type;
    logic [ADDR_W-1:0] w_s0_addr;
    logic [DATA_W-1:0] w_s0_data;
    logic [16:0]       w_drop_sum;
    logic [15:0]       w_drop_next;

    assign w_reg_ev   = i_reg_write_sig && !((FILTER_X0 != 0) && (i_reg_num == 5'd0));
    assign w_mem_ev   = i_wr || i_rd;
    assign w_n_ev     = {1'b0, w_reg_ev} + {1'b0, w_mem_ev};
    // Free space is taken before this cycle's pop, so a pop never makes room
    // for a same-cycle push.
    assign w_free     = CNT_W'(DEPTH) - r_count;
    assign w_pop      = (r_count != {CNT_W{1'b0}}) && trace_m.trace_ready;
    assign w_reg_addr = {{(ADDR_W-5){1'b0}}, i_reg_num};
    assign w_drop_sum = {1'b0, r_drop} + {15'd0, w_drop_cnt};
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // Store data takes priority when a write and read strobe coincide
    always_comb begin
        w_mem_type = TYPE_MEM_RD;
        w_mem_data = i_rd_data;
        if (i_wr) begin
            w_mem_type = TYPE_MEM_WR;
            w_mem_data = i_wr_data;
        end else begin
            w_mem_type = TYPE_MEM_RD;
            w_mem_data = i_rd_data;
        end
    end

    // Slot 0 holds the oldest event of the cycle: REG if present, else MEM
    always_comb begin
        w_s0_type = w_mem_type;
        w_s0_addr = i_addr;
        w_s0_data = w_mem_data;
        if (w_reg_ev) begin
            w_s0_type = TYPE_REG;
            w_s0_addr = w_reg_addr;
            w_s0_data = i_reg_data;
        end else begin
            w_s0_type = w_mem_type;
            w_s0_addr = i_addr;
            w_s0_data = w_mem_data;
        end
    end

    // Decide how many records fit; the younger MEM record is dropped first
    always_comb begin
        w_push_cnt = 2'd0;
        w_drop_cnt = 2'd0;
        if (w_free >= CNT_W'(2'd2)) begin
            w_push_cnt = w_n_ev;
            w_drop_cnt = 2'd0;
        end else if (w_free == CNT_W'(2'd1)) begin
            w_push_cnt = (w_n_ev != 2'd0) ? 2'd1 : 2'd0;
            w_drop_cnt = w_n_ev - w_push_cnt;
        end else begin
            w_push_cnt = 2'd0;
            w_drop_cnt = w_n_ev;
        end
    end

    // FIFO storage, pointers, occupancy and drop statistics
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_type[i] <= 2'b00;
                r_addr[i] <= {ADDR_W{1'b0}};
                r_data[i] <= {DATA_W{1'b0}};
            end
            r_wptr     <= {PTR_W{1'b0}};
            r_rptr     <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_drop     <= 16'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_cnt != 2'd0) begin
                r_type[r_wptr] <= w_s0_type;
                r_addr[r_wptr] <= w_s0_addr;
                r_data[r_wptr] <= w_s0_data;
            end
            if (w_push_cnt == 2'd2) begin
                r_type[r_wptr + PTR_W'(1'b1)] <= w_mem_type;
                r_addr[r_wptr + PTR_W'(1'b1)] <= i_addr;
                r_data[r_wptr + PTR_W'(1'b1)] <= w_mem_data;
            end
            r_wptr  <= r_wptr + PTR_W'(w_push_cnt);
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop);
            r_drop  <= w_drop_next;
            if (w_drop_cnt != 2'd0) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // First-word-fall-through head presentation
    assign trace_m.trace_valid = (r_count != {CNT_W{1'b0}});
    assign trace_m.trace_type  = r_type[r_rptr];
    assign trace_m.trace_addr  = r_addr[r_rptr];
    assign trace_m.trace_data  = r_data[r_rptr];

    assign o_fifo_count = r_count;
    assign o_drop_count = r_drop;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: reset, single and dual pushes,
// x0 filtering, write/read priority, overflow/drop accounting, pointer wrap
// and mid-stream reset.
module tb_commit_trace_buffer;

    typedef struct packed {
        logic [1:0]  t;
        logic [8:0]  a;
        logic [31:0] d;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [4:0]  fifo_count;
    logic [15:0] drop_count;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    rec_t exp_q[$];

    commit_trace_buffer_if #(.DATA_W(32), .ADDR_W(9)) trace_bus ();

    commit_trace_buffer #(
        .DATA_W(32), .ADDR_W(9), .DEPTH(16), .FILTER_X0(1)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_reg_write_sig(reg_write_sig),
        .i_reg_num      (reg_num),
        .i_reg_data     (reg_data),
        .i_wr           (wr),
        .i_rd           (rd),
        .i_addr         (addr),
        .i_wr_data      (wr_data),
        .i_rd_data      (rd_data),
        .trace_m        (trace_bus),
        .o_fifo_count   (fifo_count),
        .o_drop_count   (drop_count),
        .o_overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_write_sig = 1'b0; reg_num = 5'd0; reg_data = 32'd0;
        wr = 1'b0; rd = 1'b0; addr = 9'd0; wr_data = 32'd0; rd_data = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        trace_bus.trace_ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (trace_bus.trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", trace_bus.trace_valid); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== 43'd0) begin
            errors++; $display("FAIL reset_head got=%h/%h/%h exp=0/0/0", trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data);
        end
    endtask

    task automatic test_single_reg();
        trace_bus.trace_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
        tick();
        idle_inputs();
        checks++; if (trace_bus.trace_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", trace_bus.trace_valid); end
        checks++; if (trace_bus.trace_type !== 2'b01) begin errors++; $display("FAIL single_type got=%b exp=01", trace_bus.trace_type); end
        checks++; if (trace_bus.trace_addr !== 9'd5) begin errors++; $display("FAIL single_addr got=%h exp=005", trace_bus.trace_addr); end
        checks++; if (trace_bus.trace_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", trace_bus.trace_data); end
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        tick();
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_drain got=%0d exp=0", fifo_count); end
        checks++; if (trace_bus.trace_valid !== 1'b0) begin errors++; $display("FAIL single_valid0 got=%b exp=0", trace_bus.trace_valid); end
    endtask

    task automatic test_dual_push();
        trace_bus.trace_ready = 1'b0;
        reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h11;
        wr = 1'b1; addr = 9'h1A4; wr_data = 32'h22;
        tick();
        idle_inputs();
        checks++; if (fifo_count !== 5'd2) begin errors++; $display("FAIL dual_count got=%0d exp=2", fifo_count); end
        checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== {2'b01, 9'd7, 32'h11}) begin
            errors++; $display("FAIL dual_first got=%b/%h/%h exp=01/007/00000011", trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data);
        end
        trace_bus.trace_ready = 1'b1;
        tick();
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL dual_count1 got=%0d exp=1", fifo_count); end
        checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== {2'b10, 9'h1A4, 32'h22}) begin
            errors++; $display("FAIL dual_second got=%b/%h/%h exp=10/1a4/00000022", trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data);
        end
        tick();
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL dual_drain got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_filter_priority();
        trace_bus.trace_ready = 1'b0;
        reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h99;
        wr = 1'b1; rd = 1'b1; addr = 9'h033; wr_data = 32'hAA; rd_data = 32'hBB;
        tick();
        idle_inputs();
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL filter_count got=%0d exp=1", fifo_count); end
        checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== {2'b10, 9'h033, 32'hAA}) begin
            errors++; $display("FAIL wr_priority got=%b/%h/%h exp=10/033/000000aa", trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data);
        end
        // Pop the MEM_WR while a load arrives in the same cycle
        trace_bus.trace_ready = 1'b1;
        rd = 1'b1; addr = 9'h044; rd_data = 32'hCC;
        tick();
        idle_inputs();
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL pushpop_count got=%0d exp=1", fifo_count); end
        checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== {2'b11, 9'h044, 32'hCC}) begin
            errors++; $display("FAIL mem_rd got=%b/%h/%h exp=11/044/000000cc", trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data);
        end
        tick();
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL filter_drain got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_overflow();
        trace_bus.trace_ready = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            reg_write_sig = 1'b1; reg_num = 5'(i); reg_data = 32'h100 + 32'(i);
            exp_q.push_back({2'b01, 9'(i), 32'h100 + 32'(i)});
            tick();
        end
        idle_inputs();
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL fill_count got=%0d exp=15", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf got=%b exp=0", overflow); end
        // One free slot, two events: REG kept, MEM dropped
        reg_write_sig = 1'b1; reg_num = 5'd20; reg_data = 32'h500;
        wr = 1'b1; addr = 9'h055; wr_data = 32'h200;
        exp_q.push_back({2'b01, 9'd20, 32'h500});
        tick();
        idle_inputs();
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", fifo_count); end
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL drop1 got=%0d exp=1", drop_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        reg_write_sig = 1'b1; reg_num = 5'd21; reg_data = 32'h600;
        tick();
        idle_inputs();
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL drop2 got=%0d exp=2", drop_count); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_hold got=%0d exp=16", fifo_count); end
        reg_write_sig = 1'b1; reg_num = 5'd22; reg_data = 32'h700;
        rd = 1'b1; addr = 9'h066; rd_data = 32'h800;
        tick();
        idle_inputs();
        checks++; if (drop_count !== 16'd4) begin errors++; $display("FAIL drop_dual got=%0d exp=4", drop_count); end
    endtask

    task automatic test_full_pop_and_wrap();
        // Full FIFO: pop and event in the same cycle, event still dropped
        trace_bus.trace_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd23; reg_data = 32'h900;
        void'(exp_q.pop_front());
        tick();
        idle_inputs();
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL prepop_count got=%0d exp=15", fifo_count); end
        checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL prepop_drop got=%0d exp=5", drop_count); end
        // Stream 40 records while popping one per cycle
        for (int i = 0; i < 40; i++) begin
            checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== exp_q[0]) begin
                errors++; $display("FAIL stream_head[%0d] got=%b/%h/%h exp=%b/%h/%h", i, trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data, exp_q[0].t, exp_q[0].a, exp_q[0].d);
            end
            reg_write_sig = 1'b1; reg_num = 5'((i % 30) + 1); reg_data = 32'h2000 + 32'(i);
            void'(exp_q.pop_front());
            exp_q.push_back({2'b01, 9'((i % 30) + 1), 32'h2000 + 32'(i)});
            tick();
        end
        idle_inputs();
        checks++; if (fifo_count !== 5'd15) begin errors++; $display("FAIL stream_count got=%0d exp=15", fifo_count); end
        checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL stream_drop got=%0d exp=5", drop_count); end
        for (int i = 0; i < 15; i++) begin
            checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== exp_q[0]) begin
                errors++; $display("FAIL drain_head[%0d] got=%b/%h/%h exp=%b/%h/%h", i, trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data, exp_q[0].t, exp_q[0].a, exp_q[0].d);
            end
            void'(exp_q.pop_front());
            tick();
        end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL wrap_drain got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_reset_midstream();
        trace_bus.trace_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1; addr = 9'(i); wr_data = 32'(i);
            tick();
        end
        idle_inputs();
        checks++; if (fifo_count !== 5'd9) begin errors++; $display("FAIL mid_count got=%0d exp=9", fifo_count); end
        reset = 1'b1;
        trace_bus.trace_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'h33;
        wr = 1'b1; addr = 9'h0AB; wr_data = 32'h44;
        tick();
        reset = 1'b0;
        idle_inputs();
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", fifo_count); end
        checks++; if (trace_bus.trace_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", trace_bus.trace_valid); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL mid_reset_drop got=%0d exp=0", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf got=%b exp=0", overflow); end
        checks++; if ({trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data} !== 43'd0) begin
            errors++; $display("FAIL mid_reset_head got=%b/%h/%h exp=0/0/0", trace_bus.trace_type, trace_bus.trace_addr, trace_bus.trace_data);
        end
        tick();
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mid_reset_after got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        reset = 1'b1;
        trace_bus.trace_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single_reg();
        test_dual_push();
        test_filter_priority();
        test_overflow();
        test_full_pop_and_wrap();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
